// File: rtl/seg7_pkg.sv
// Shared constants, state encoding and leading-zero helper for the BCD front end.
// Latency: n/a (package). Backpressure: n/a.
package seg7_pkg;

    localparam int BCD_W   = 4;
    localparam int DIGITS  = 6;
    localparam int MAX_VAL = 999999;
    localparam int BCD_TOT = BCD_W * DIGITS;

    localparam logic [BCD_TOT-1:0] SAT_BCD  = {DIGITS{4'h9}};
    localparam logic [DIGITS-1:0]  LZ_RESET = {{(DIGITS-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    function automatic logic [DIGITS-1:0] lz_mask_of(input logic [BCD_TOT-1:0] v);
        logic [DIGITS-1:0] m;
        logic              z;
        m = '0;
        z = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            z    = z && (v[i*BCD_W +: BCD_W] == 4'd0);
            m[i] = z;
        end
        return m;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Latency: combinational. Backpressure: none.
module bcd_add3 (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin_to_bcd6.sv
// Binary to 6-digit packed BCD via shift-and-add-3, one bit per clock, with leading-zero mask.
// Latency: BIN_W+1 cycles start-to-done. Backpressure: start ignored while busy, no queueing.
module bin_to_bcd6
    import seg7_pkg::*;
#(
    parameter int BIN_W = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BIN_W-1:0]   bin,
    output logic               busy,
    output logic               done,
    output logic [BCD_TOT-1:0] bcd,
    output logic [DIGITS-1:0]  lz_mask,
    output logic               ovf
);

    localparam int               CNT_W   = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] MAX_BIN = BIN_W'(MAX_VAL);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [BIN_W-1:0]     shreg_q;
    logic [BCD_TOT-1:0]   scratch_q;
    logic [BCD_TOT-1:0]   corr;
    logic [BCD_TOT-1:0]   result;
    logic                 ovf_cap_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .d (scratch_q[g*BCD_W +: BCD_W]),
            .q (corr[g*BCD_W +: BCD_W])
        );
    end

    // Out-of-range inputs overflow the scratch digits, so the result is replaced outright.
    assign result = ovf_cap_q ? SAT_BCD : scratch_q;
    assign busy   = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == CNT_W'(BIN_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            ovf_cap_q <= 1'b0;
            done      <= 1'b0;
            bcd       <= '0;
            lz_mask   <= LZ_RESET;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shreg_q   <= bin;
                        scratch_q <= '0;
                        cnt_q     <= '0;
                        ovf_cap_q <= (bin > MAX_BIN);
                    end
                end
                SHIFT: begin
                    {scratch_q, shreg_q} <= {corr, shreg_q} << 1;
                    cnt_q                <= cnt_q + CNT_W'(1);
                end
                DONE: begin
                    bcd     <= result;
                    lz_mask <= lz_mask_of(result);
                    ovf     <= ovf_cap_q;
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd6.sv
// Randomized scoreboard bench for bin_to_bcd6 against an arithmetic decimal model.
module tb_bin_to_bcd6;

    typedef struct {
        int          due;
        logic [23:0] bcd;
        logic [5:0]  lz;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] bin;
    logic        busy;
    logic        done;
    logic [23:0] bcd;
    logic [5:0]  lz_mask;
    logic        ovf;

    exp_t sb[$];
    exp_t held;
    int   edge_n  = 0;
    int   free_at = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    bit   mon_en  = 0;

    bin_to_bcd6 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd),
        .lz_mask (lz_mask),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic exp_t model(input int v, input int due);
        exp_t e;
        int   p;
        e.due = due;
        e.bcd = '0;
        e.lz  = '0;
        e.ovf = 1'b0;
        if (v > 999999) begin
            e.bcd = 24'h999999;
            e.ovf = 1'b1;
        end else begin
            p = 1;
            for (int i = 0; i < 6; i++) begin
                e.bcd[i*4 +: 4] = 4'((v / p) % 10);
                e.lz[i]         = (i > 0) && (v < p);
                p               = p * 10;
            end
        end
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.due = 0;
        e.bcd = 24'h000000;
        e.lz  = 6'b111110;
        e.ovf = 1'b0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, edge_n);
        end
    endtask

    // One clock: drive inputs, update the model at the edge using the idle/accept rule.
    task automatic step(input logic s, input logic [19:0] b, input logic r);
        start = s;
        bin   = b;
        rst   = r;
        @(posedge clk);
        edge_n++;
        if (r) begin
            sb.delete();
            held    = reset_exp();
            free_at = 0;
        end else if (s && edge_n >= free_at) begin
            sb.push_back(model(int'(b), edge_n + 21));
            free_at = edge_n + 22;
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 20'h0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && edge_n > sb[0].due) begin
                chk("missing_done", 32'(done), 32'd1);
                void'(sb.pop_front());
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    held = sb.pop_front();
                    chk("done_latency", 32'(edge_n), 32'(held.due));
                    chk("bcd", 32'(bcd), 32'(held.bcd));
                    chk("lz_mask", 32'(lz_mask), 32'(held.lz));
                    chk("ovf", 32'(ovf), 32'(held.ovf));
                end
            end else begin
                chk("bcd_hold", 32'(bcd), 32'(held.bcd));
                chk("lz_hold", 32'(lz_mask), 32'(held.lz));
                chk("ovf_hold", 32'(ovf), 32'(held.ovf));
            end
            chk("busy", 32'(busy), 32'(edge_n + 2 <= free_at));
        end
    end

    initial begin
        int dir_vals[6];
        int v;
        dir_vals = '{0, 123456, 999999, 42, 1000000, 20'hFFFFF};
        held  = reset_exp();
        start = 1'b0;
        bin   = '0;
        rst   = 1'b1;
        step(1'b0, 20'h0, 1'b1);
        step(1'b0, 20'h0, 1'b1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_bcd", 32'(bcd), 32'h0);
        chk("reset_lz", 32'(lz_mask), 32'h3E);
        chk("reset_ovf", 32'(ovf), 32'd0);
        mon_en = 1;
        step(1'b0, 20'h0, 1'b0);

        foreach (dir_vals[i]) begin
            step(1'b1, 20'(dir_vals[i]), 1'b0);
            idle(21 + i % 3);
        end

        // Second start five cycles into a conversion must be dropped.
        step(1'b1, 20'd555555, 1'b0);
        idle(4);
        step(1'b1, 20'd7, 1'b0);
        idle(20);

        // Abort mid-conversion, then convert again.
        step(1'b1, 20'd654321, 1'b0);
        idle(9);
        step(1'b0, 20'h0, 1'b1);
        step(1'b0, 20'h0, 1'b0);
        step(1'b1, 20'd31415, 1'b0);
        idle(22);

        // start held high with bin changing every cycle.
        for (int i = 0; i < 8 * 22; i++) step(1'b1, 20'($urandom_range(0, 20'hFFFFF)), 1'b0);
        idle(2);

        for (int i = 0; i < 700; i++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(999990, 1000010);
                2:       v = $urandom_range(0, 20'hFFFFF);
                default: v = $urandom_range(0, 999999);
            endcase
            step(($urandom_range(0, 9) < 3), 20'(v), 1'b0);
        end

        idle(25);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
